// File: rtl/alu_16_sequencer_if.sv
// Byte-wide link between the 16-bit sequencer (master) and the shared combinational 8-bit ALU (slave).
interface alu_16_sequencer_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_b;
    logic [2:0]            alu_opcode;   // 0 ADD, 1 ADC, 2 SUB, 3 SBC
    logic                  alu_carry_in;
    logic                  alu_enable;
    logic [DATA_WIDTH-1:0] alu_out;
    logic [7:0]            alu_status;   // S Z Y H X P/V N C

    modport master (
        output alu_a,
        output alu_b,
        output alu_opcode,
        output alu_carry_in,
        output alu_enable,
        input  alu_out,
        input  alu_status
    );

    modport slave (
        input  alu_a,
        input  alu_b,
        input  alu_opcode,
        input  alu_carry_in,
        input  alu_enable,
        output alu_out,
        output alu_status
    );
endinterface

// File: rtl/alu_16_sequencer.sv
// Runs Z80-style 16-bit ADD/ADC/SBC/INC/DEC as two byte passes (low then high) through a shared 8-bit ALU.
module alu_16_sequencer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [2:0]                op,
    input  logic [2*DATA_WIDTH-1:0]   a,
    input  logic [2*DATA_WIDTH-1:0]   b,
    input  logic [7:0]                flags_in,
    output logic [2*DATA_WIDTH-1:0]   result,
    output logic [7:0]                flags_out,
    output logic                      busy,
    output logic                      done,
    alu_16_sequencer_if.master        alu
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    typedef enum logic [2:0] {
        OP_ADD16 = 3'd0,
        OP_ADC16 = 3'd1,
        OP_SBC16 = 3'd2,
        OP_INC16 = 3'd3,
        OP_DEC16 = 3'd4
    } op_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_ADC = 3'd1,
        ALU_SUB = 3'd2,
        ALU_SBC = 3'd3
    } alu_op_t;

    state_t                    state, state_next;
    logic [2:0]                op_q;
    logic [2*DATA_WIDTH-1:0]   a_q, b_q;
    logic [7:0]                f_q;
    logic [DATA_WIDTH-1:0]     lo_q;
    logic                      cy_q, z_lo_q;
    logic                      op_legal, inc_dec;
    logic [2*DATA_WIDTH-1:0]   result_next;
    logic [7:0]                flags_next;

    assign op_legal = (op_q <= OP_DEC16);
    assign inc_dec  = (op_q == OP_INC16) || (op_q == OP_DEC16);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            f_q       <= '0;
            lo_q      <= '0;
            cy_q      <= 1'b0;
            z_lo_q    <= 1'b0;
            result    <= '0;
            flags_out <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (start) begin
                    op_q <= op;
                    a_q  <= a;
                    b_q  <= b;
                    f_q  <= flags_in;
                end
                LOW: if (op_legal) begin
                    lo_q   <= alu.alu_out;
                    cy_q   <= alu.alu_status[0];
                    z_lo_q <= alu.alu_status[6];
                end
                // The high byte result and status are consumed straight off the ALU on entry to DONE.
                HIGH: begin
                    result    <= result_next;
                    flags_out <= flags_next;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        result_next = op_legal ? {alu.alu_out, lo_q} : a_q;
        flags_next  = f_q;
        case (op_q)
            OP_ADD16: flags_next = {f_q[7:6], alu.alu_status[5:3], f_q[2], 1'b0, alu.alu_status[0]};
            OP_ADC16,
            OP_SBC16: flags_next = {alu.alu_status[7], z_lo_q & alu.alu_status[6], alu.alu_status[5:0]};
            default:  flags_next = f_q;
        endcase
    end

    always_comb begin
        state_next       = state;
        busy             = (state != IDLE);
        done             = (state == DONE);
        alu.alu_a        = '0;
        alu.alu_b        = '0;
        alu.alu_opcode   = ALU_ADD;
        alu.alu_carry_in = 1'b0;
        alu.alu_enable   = 1'b0;
        case (state)
            IDLE: if (start) state_next = LOW;
            LOW: begin
                state_next = HIGH;
                if (op_legal) begin
                    alu.alu_enable   = 1'b1;
                    alu.alu_a        = a_q[DATA_WIDTH-1:0];
                    alu.alu_b        = inc_dec ? DATA_WIDTH'(1) : b_q[DATA_WIDTH-1:0];
                    alu.alu_carry_in = (op_q == OP_ADC16 || op_q == OP_SBC16) ? f_q[0] : 1'b0;
                    case (op_q)
                        OP_ADC16: alu.alu_opcode = ALU_ADC;
                        OP_SBC16: alu.alu_opcode = ALU_SBC;
                        OP_DEC16: alu.alu_opcode = ALU_SUB;
                        default:  alu.alu_opcode = ALU_ADD;
                    endcase
                end
            end
            HIGH: begin
                state_next = DONE;
                if (op_legal) begin
                    alu.alu_enable   = 1'b1;
                    alu.alu_a        = a_q[2*DATA_WIDTH-1:DATA_WIDTH];
                    alu.alu_b        = inc_dec ? '0 : b_q[2*DATA_WIDTH-1:DATA_WIDTH];
                    alu.alu_carry_in = cy_q;
                    alu.alu_opcode   = (op_q == OP_SBC16 || op_q == OP_DEC16) ? ALU_SBC : ALU_ADC;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_16_sequencer.sv
// Scoreboard bench for alu_16_sequencer: a bench-side 8-bit ALU serves the DUT, a 16-bit arithmetic model predicts results.
module tb_alu_16_sequencer;

    localparam logic [2:0] ALU_ADC = 3'd1;
    localparam logic [2:0] ALU_SUB = 3'd2;
    localparam logic [2:0] ALU_SBC = 3'd3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [7:0]  flags_in = '0;
    logic [15:0] result;
    logic [7:0]  flags_out;
    logic        busy;
    logic        done;

    alu_16_sequencer_if #(.DATA_WIDTH(8)) alu_if ();

    alu_16_sequencer #(.DATA_WIDTH(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .flags_in  (flags_in),
        .result    (result),
        .flags_out (flags_out),
        .busy      (busy),
        .done      (done),
        .alu       (alu_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] res;
        logic [7:0]  fl;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cnt = 0;
    bit          cur_legal = 1'b0;
    bit          mon_on = 1'b0;
    logic [15:0] held_res = '0;
    logic [7:0]  held_fl = '0;

    // Z80-style 8-bit ALU: returns {status, out}
    function automatic logic [15:0] alu8(input logic [2:0] opc, input logic [7:0] x,
                                         input logic [7:0] y, input logic ci);
        logic [8:0] r;
        logic [4:0] h;
        logic c, sub, v;
        sub = (opc == ALU_SUB) || (opc == ALU_SBC);
        c   = (opc == ALU_ADC || opc == ALU_SBC) ? ci : 1'b0;
        if (sub) begin
            r = {1'b0, x} - {1'b0, y} - {8'b0, c};
            h = {1'b0, x[3:0]} - {1'b0, y[3:0]} - {4'b0, c};
            v = (x[7] != y[7]) && (r[7] != x[7]);
        end else begin
            r = {1'b0, x} + {1'b0, y} + {8'b0, c};
            h = {1'b0, x[3:0]} + {1'b0, y[3:0]} + {4'b0, c};
            v = (x[7] == y[7]) && (r[7] != x[7]);
        end
        return {r[7], r[7:0] == 8'h00, r[5], h[4], r[3], v, sub, r[8], r[7:0]};
    endfunction

    assign {alu_if.alu_status, alu_if.alu_out} =
        alu8(alu_if.alu_opcode, alu_if.alu_a, alu_if.alu_b, alu_if.alu_carry_in);

    // Whole-word reference: result and F computed directly on 16-bit operands
    function automatic exp_t ref16(input logic [2:0] o, input logic [15:0] x,
                                   input logic [15:0] y, input logic [7:0] f);
        exp_t e;
        logic [16:0] s;
        logic [12:0] h;
        logic c, v;
        c = f[0];
        e.res = x;
        e.fl  = f;
        case (o)
            3'd0: begin
                s = {1'b0, x} + {1'b0, y};
                h = {1'b0, x[11:0]} + {1'b0, y[11:0]};
                e.res = s[15:0];
                e.fl  = {f[7:6], s[13], h[12], s[11], f[2], 1'b0, s[16]};
            end
            3'd1: begin
                s = {1'b0, x} + {1'b0, y} + {16'b0, c};
                h = {1'b0, x[11:0]} + {1'b0, y[11:0]} + {12'b0, c};
                v = (x[15] == y[15]) && (s[15] != x[15]);
                e.res = s[15:0];
                e.fl  = {s[15], s[15:0] == 16'h0, s[13], h[12], s[11], v, 1'b0, s[16]};
            end
            3'd2: begin
                s = {1'b0, x} - {1'b0, y} - {16'b0, c};
                h = {1'b0, x[11:0]} - {1'b0, y[11:0]} - {12'b0, c};
                v = (x[15] != y[15]) && (s[15] != x[15]);
                e.res = s[15:0];
                e.fl  = {s[15], s[15:0] == 16'h0, s[13], h[12], s[11], v, 1'b1, s[16]};
            end
            3'd3:    e.res = x + 16'd1;
            3'd4:    e.res = x - 16'd1;
            default: ;
        endcase
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] pick16();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // Transaction model: an accepted start keeps the block busy for three cycles; done on the last.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt = 0;
            q.delete();
        end else if (cnt == 0) begin
            if (start) begin
                cnt = 3;
                cur_legal = (op <= 3'd4);
                q.push_back(ref16(op, a, b, flags_in));
            end
        end else begin
            cnt = cnt - 1;
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            if (!reset_n) begin
                held_res = '0;
                held_fl  = '0;
            end
            check("busy", 32'(busy), 32'(cnt != 0));
            if (cnt == 1) begin
                check("done", 32'(done), 32'd1);
                if (q.size() != 0) begin
                    mon_e = q.pop_front();
                    check("sb_result", 32'(result), 32'(mon_e.res));
                    check("sb_flags", 32'(flags_out), 32'(mon_e.fl));
                    held_res = mon_e.res;
                    held_fl  = mon_e.fl;
                end else begin
                    check("sb_entry", 32'(q.size()), 32'd1);
                end
            end else begin
                check("no_done", 32'(done), 32'd0);
            end
            check("result_hold", 32'(result), 32'(held_res));
            check("flags_hold", 32'(flags_out), 32'(held_fl));
            if (cnt >= 2 && cur_legal)
                check("alu_enable", 32'(alu_if.alu_enable), 32'd1);
            else
                check("alu_quiet", 32'({alu_if.alu_a, alu_if.alu_b, alu_if.alu_opcode,
                                        alu_if.alu_carry_in, alu_if.alu_enable}), 32'd0);
        end
    end

    task automatic run_op(input string name, input logic [2:0] o, input logic [15:0] x,
                          input logic [15:0] y, input logic [7:0] f,
                          input logic [15:0] er, input logic [7:0] ef);
        int lat;
        @(posedge clk); #1;
        op = o; a = x; b = y; flags_in = f; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = ~x; b = ~y; flags_in = ~f;
        lat = 1;
        while (!done && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'd3);
        check({name, "_result"}, 32'(result), 32'(er));
        check({name, "_flags"}, 32'(flags_out), 32'(ef));
        @(posedge clk); #1;
    endtask

    initial begin
        int ndone;
        #1 reset_n = 1'b0;
        #1;
        check("reset_result", 32'(result), 32'd0);
        check("reset_flags", 32'(flags_out), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_alu", 32'({alu_if.alu_a, alu_if.alu_b, alu_if.alu_opcode,
                                alu_if.alu_carry_in, alu_if.alu_enable}), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        mon_on = 1'b1;

        run_op("add16", 3'd0, 16'h0FFF, 16'h0001, 8'hC4, 16'h1000, 8'hD4);
        run_op("adc16", 3'd1, 16'hFFFF, 16'h0000, 8'h01, 16'h0000, 8'h51);
        run_op("sbc16", 3'd2, 16'h8000, 16'h0001, 8'h00, 16'h7FFF, 8'h3E);
        run_op("inc16", 3'd3, 16'hFFFF, 16'h1234, 8'hA5, 16'h0000, 8'hA5);
        run_op("dec16", 3'd4, 16'h0000, 16'h1234, 8'h5A, 16'hFFFF, 8'h5A);
        run_op("illegal6", 3'd6, 16'h1234, 16'h5678, 8'h3C, 16'h1234, 8'h3C);

        // start held through LOW/HIGH/DONE with changing operands, then accepted once back in IDLE
        ndone = 0;
        @(posedge clk); #1;
        op = 3'd0; a = 16'($urandom); b = 16'($urandom); flags_in = 8'($urandom); start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            ndone += int'(done);
            op = 3'($urandom_range(0, 4)); a = 16'($urandom); b = 16'($urandom);
            flags_in = 8'($urandom);
        end
        @(posedge clk); #1;
        start = 1'b0;
        ndone += int'(done);
        repeat (6) begin
            @(posedge clk); #1;
            ndone += int'(done);
        end
        check("ignore_done_count", 32'(ndone), 32'd2);

        // abort during HIGH
        @(posedge clk); #1;
        op = 3'd1; a = 16'h4321; b = 16'h1111; flags_in = 8'h01; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("abort_result", 32'(result), 32'd0);
        check("abort_flags", 32'(flags_out), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_alu_enable", 32'(alu_if.alu_enable), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        run_op("after_reset", 3'd0, 16'h1234, 16'h4321, 8'h00, 16'h5555, 8'h00);

        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            start = ($urandom_range(0, 2) != 0);
            op = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            a = pick16();
            b = pick16();
            flags_in = 8'($urandom);
        end
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("drain", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_16_sequencer.md
ALU_16_SEQUENCER -- requirements
Module: alu_16_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the byte width of the shared 8-bit ALU; only 8 is supported.
REQ-002 SHALL have clk, input, 1: the single clock; all state changes on rising edge.
REQ-003 SHALL have reset_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have start, input, 1: request a 16-bit operation; sampled only in IDLE.
REQ-005 SHALL have op, input, 3: 0 ADD16, 1 ADC16, 2 SBC16, 3 INC16, 4 DEC16, 5-7 illegal.
REQ-006 SHALL have a and b, input, 16 each: operands.
REQ-007 SHALL have flags_in, input, 8: current F register, Z80 layout S Z Y H X P/V N C (bit 7..0). Bit 0 is carry-in for ADC16/SBC16.
REQ-008 SHALL have result, output, 16, and flags_out, output, 8: registered results.
REQ-009 SHALL have busy, output, 1, and done, output, 1: done is a one-cycle pulse.
REQ-010 SHALL have these ALU-side signals: alu_a, output, 8; alu_b, output, 8; alu_opcode, output, alu_op; alu_carry_in, output, 1; alu_enable, output, 1; alu_out, input, 8; alu_status, input, 8. The ALU is combinational, and its status uses the same flag layout.

Function
REQ-011 SHALL implement the FSM states and transitions IDLE -> LOW -> HIGH -> DONE -> IDLE.
- IDLE -> LOW on start=1, latching op, a, b and flags_in.
- LOW, HIGH and DONE each last exactly one cycle.
REQ-012 busy SHALL be 1 in LOW, HIGH and DONE, and 0 in IDLE.
REQ-013 start SHALL be ignored while busy, including in DONE; operand changes after acceptance SHALL have no effect.
REQ-014 done SHALL be asserted during DONE only, so latency is start-cycle + 3 edges; result and flags_out SHALL be updated on entry to DONE and held until the next DONE.
REQ-015 alu_enable SHALL be 1 only in LOW and HIGH for legal ops; in other states all alu_* outputs SHALL be 0.
REQ-016 LOW step SHALL drive alu_a=a[7:0] and select operand/opcode as follows:
- ADD16/ADC16: alu_b=b[7:0], ADD/ADC.
- SBC16: alu_b=b[7:0], SBC.
- INC16: alu_b=1, ADD.
- DEC16: alu_b=1, SUB.
- alu_carry_in=latched flags_in[0] for ADC16/SBC16, else 0.
- Latch lo=alu_out, cy=alu_status[0], z_lo=alu_status[6].
REQ-017 HIGH step SHALL drive alu_a=a[15:8]; alu_b=b[15:8] (0 for INC16/DEC16); opcode ADC (ADD16/ADC16/INC16) or SBC (SBC16/DEC16); alu_carry_in=cy; latch hi=alu_out and hs=alu_status.
REQ-018 result SHALL be {hi, lo}.
REQ-019 ADD16 SHALL produce flags_out {flags_in[7:6], hs[5], hs[4], hs[3], flags_in[2], 0, hs[0]}.
REQ-020 ADC16/SBC16 SHALL produce flags_out {hs[7], z_lo & hs[6], hs[5:1], hs[0]}, i.e. Z is 16-bit zero, and N=1 for SBC16.
REQ-021 INC16/DEC16 SHALL leave flags_out equal to latched flags_in.
REQ-022 Illegal op SHALL keep ALU disabled, give result=a and flags_out=flags_in, and complete with identical latency.
REQ-023 Wrap-around SHALL be modulo 2^16 with no extra indication beyond C.

Reset
REQ-024 When reset_n=0, the block SHALL asynchronously enter IDLE with result=0, flags_out=0, busy=0, done=0, all alu_* outputs 0, and internal latches 0.
REQ-025 Reset asserted mid-operation SHALL abort it with no done pulse; the first start after release SHALL behave normally.

Verification
REQ-026 ADD16 a=0x0FFF b=0x0001 flags_in=0xC4 -> result 0x1000, flags_out bit4(H)=1, bit0(C)=0, bit1(N)=0, bits7,6,2 = 1,1,1 preserved, done 3 cycles after start.
REQ-027 ADC16 a=0xFFFF b=0x0000 flags_in C=1 -> result 0x0000, Z=1, C=1, H=1, S=0.
REQ-028 SBC16 a=0x8000 b=0x0001 C=0 -> result 0x7FFF, P/V=1, N=1, H=1, S=0, C=0.
REQ-029 INC16 a=0xFFFF -> result 0x0000 with flags_out==flags_in; DEC16 a=0x0000 -> result 0xFFFF, flags unchanged.
REQ-030 start pulsed in LOW, HIGH and DONE with new operands -> ignored, exactly one done pulse; back-to-back start in the cycle after DONE -> accepted.
REQ-031 reset_n low during HIGH -> outputs 0 immediately, no done pulse; op=6 -> result=a, flags_out=flags_in, alu_enable never 1.
